cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field against it.
- Gates PC, register-file and memory write enables from the decoder.
- Sits between decoder, ALU and datapath in the ARM core. Supports single-cycle (combinational CondEx) or multicycle (latched CondEx) operation.

Parameters:
- MULTICYCLE, 0, 0 = CondEx combinational each cycle; 1 = CondEx captured on CondLatch and held.
- CNT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- FlagW  in  2  [1] = update N,Z; [0] = update C,V (decoder).
- PCS  in  1  instruction writes PC.
- RegW  in  1  instruction writes register file.
- MemW  in  1  instruction writes memory.
- NoWrite  in  1  CMP-style instruction; suppresses RegWrite.
- CondLatch  in  1  multicycle decode strobe; ignored when MULTICYCLE=0.
- PCSrc  out  1  PCS & CondEx.
- RegWrite  out  1  RegW & CondEx & !NoWrite.
- MemWrite  out  1  MemW & CondEx.
- Flags  out  4  registered {N,Z,C,V}.
- CondEx  out  1  effective condition-pass signal.

Behaviour:
- Reset, synchronous at next rising clk: Flags=4'b0000; CondEx_r=0; counters=0. All outputs follow combinationally: PCSrc=RegWrite=MemWrite=0 when MULTICYCLE=1.
- Condition eval (CondRaw, combinational on Cond and registered Flags), N,Z,C,V = Flags[3:0]:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1.
- MULTICYCLE=0: CondEx=CondRaw. MULTICYCLE=1: CondEx_r<=CondRaw on a clk edge with CondLatch=1, otherwise held. CondEx=CondEx_r.
- Flag update at clk edge:
  - Flags[3:2]<=ALUFlags[3:2] iff FlagW[1]&CondEx.
  - Flags[1:0]<=ALUFlags[1:0] iff FlagW[0]&CondEx.
  - Otherwise hold.
- Latency: flags are visible on Flags/CondRaw one cycle after the write. No same-cycle bypass.
- Simultaneous CondLatch and FlagW (MULTICYCLE=1): the flag write uses the old CondEx_r. The new CondEx_r is evaluated from the pre-update Flags.
- A failed condition suppresses all three write enables and any flag update. The instruction is architecturally a NOP.
- Reset mid-instruction: CondEx_r cleared, so pending writes are squashed the cycle after reset.
- ALUFlags values under FlagW=0 are don't-care. The register holds.

Optional Feature:
- Macro COND_STATS_EN.
- Defined: adds outputs ExecCount[CNT_W-1:0] and SkipCount[CNT_W-1:0].
  - Evaluation strobe = 1 every cycle (MULTICYCLE=0) or CondLatch (MULTICYCLE=1).
  - On a strobe, ExecCount increments if CondRaw=1, else SkipCount increments.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package cond_pkg:
  - Condition-code localparams COND_EQ..COND_AL (4'h0..4'hE), COND_NV (4'hF).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW bit names FLAGW_NZ=1, FLAGW_CV=0.
- One natural sub-module: cond_check, the purely combinational Cond x Flags -> CondRaw evaluator. It is reused by the decoder's branch-prediction stub.

Test Plan:
- Reset behaviour: assert reset one cycle with ALUFlags=4'hF, FlagW=2'b11 -> Flags=0, CondEx_r=0. Cond=EQ then gives CondEx=0.
- Flag update: Cond=AL, FlagW=2'b10, ALUFlags=4'b0110 -> after edge Flags=4'b0100. Then FlagW=2'b01, ALUFlags=4'b1011 -> Flags=4'b0111.
- Condition sweep: for each Flags value 0..15 and Cond 0..15, compare CondEx to the table (256 checks). Spot check Flags=4'b1001 (N=1,V=1): GE=1, LT=0, GT=1.
- Write gating: Flags Z=1, Cond=NE, PCS=RegW=MemW=1, FlagW=2'b11 -> PCSrc=RegWrite=MemWrite=0, Flags unchanged. Cond=EQ with NoWrite=1 -> RegWrite=0, MemWrite=1.
- Multicycle latch (MULTICYCLE=1): CondLatch with Flags Z=1, Cond=EQ -> CondEx=1 held for 3 cycles while Cond changes to NE. Same-edge CondLatch+FlagW -> new CondEx uses old flags.
- COND_STATS_EN with CNT_W=4: 20 passing strobes -> ExecCount saturates at 4'hF. 3 failing strobes -> SkipCount=3. Reset -> both 0.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared condition-code encodings and NZCV / FlagW bit positions for the
// condition unit and anything else that evaluates ARM condition fields.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator: Cond x NZCV -> pass/fail.
// Also used by the decoder's branch-prediction stub.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondRaw
);

    logic n, z, c, v, ge;

    assign n  = Flags[FLAG_N];
    assign z  = Flags[FLAG_Z];
    assign c  = Flags[FLAG_C];
    assign v  = Flags[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        CondRaw = 1'b1;
        case (Cond)
            COND_EQ: CondRaw = z;
            COND_NE: CondRaw = ~z;
            COND_CS: CondRaw = c;
            COND_CC: CondRaw = ~c;
            COND_MI: CondRaw = n;
            COND_PL: CondRaw = ~n;
            COND_VS: CondRaw = v;
            COND_VC: CondRaw = ~v;
            COND_HI: CondRaw = c & ~z;
            COND_LS: CondRaw = ~c | z;
            COND_GE: CondRaw = ge;
            COND_LT: CondRaw = ~ge;
            COND_GT: CondRaw = ~z & ge;
            COND_LE: CondRaw = z | ~ge;
            // AL and the NV encoding both execute unconditionally
            default: CondRaw = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Architectural NZCV register, condition evaluation and write-enable gating.
// Define COND_STATS_EN to add the ExecCount/SkipCount statistics outputs.
module cond_unit
    import cond_pkg::*;
#(
    parameter int MULTICYCLE = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             CondLatch,
`ifdef COND_STATS_EN
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount,
`endif
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CondEx
);

    logic cond_raw;
    logic cond_ex_r;
    logic strobe;

    cond_check u_cond_check (
        .Cond    (Cond),
        .Flags   (Flags),
        .CondRaw (cond_raw)
    );

    // In multicycle mode the pass/fail is frozen at decode and reused by later steps
    assign strobe = (MULTICYCLE != 0) ? CondLatch : 1'b1;
    assign CondEx = (MULTICYCLE != 0) ? cond_ex_r : cond_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            cond_ex_r <= 1'b0;
        end else if (CondLatch) begin
            cond_ex_r <= cond_raw;
        end
    end

    // Flag writes see the pre-edge CondEx, so a same-edge latch cannot gate itself
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else begin
            if (FlagW[FLAGW_NZ] && CondEx)
                Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (FlagW[FLAGW_CV] && CondEx)
                Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & CondEx & ~NoWrite;
    assign MemWrite = MemW & CondEx;

`ifdef COND_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            ExecCount <= '0;
            SkipCount <= '0;
        end else if (strobe) begin
            if (cond_raw)
                ExecCount <= sat_inc(ExecCount);
            else
                SkipCount <= sat_inc(SkipCount);
        end
    end
`else
    logic unused_strobe;
    assign unused_strobe = strobe;
`endif

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  localparam int K_FLAGS = 0;
  localparam int K_CE    = 1;
  localparam int K_PC    = 2;
  localparam int K_RW    = 3;
  localparam int K_MW    = 4;
  localparam int K_EXEC  = 5;
  localparam int K_SKIP  = 6;

  typedef struct {
    string      name;
    bit         which;
    int         kind;
    logic [3:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, CondLatch;

  logic       pc0, rw0, mw0, ce0, pc1, rw1, mw1, ce1;
  logic [3:0] fl0, fl1;
`ifdef COND_STATS_EN
  logic [3:0] ec0, sc0, ec1, sc1;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  always #5 clk = ~clk;

  cond_unit #(.MULTICYCLE(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .CondLatch(CondLatch),
`ifdef COND_STATS_EN
    .ExecCount(ec0), .SkipCount(sc0),
`endif
    .PCSrc(pc0), .RegWrite(rw0), .MemWrite(mw0), .Flags(fl0), .CondEx(ce0)
  );

  cond_unit #(.MULTICYCLE(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .CondLatch(CondLatch),
`ifdef COND_STATS_EN
    .ExecCount(ec1), .SkipCount(sc1),
`endif
    .PCSrc(pc1), .RegWrite(rw1), .MemWrite(mw1), .Flags(fl1), .CondEx(ce1)
  );

  function automatic logic [3:0] actual(bit w, int k);
    logic [3:0] r;
    r = 4'hx;
    case (k)
      K_FLAGS: r = w ? fl1 : fl0;
      K_CE:    r = {3'b000, w ? ce1 : ce0};
      K_PC:    r = {3'b000, w ? pc1 : pc0};
      K_RW:    r = {3'b000, w ? rw1 : rw0};
      K_MW:    r = {3'b000, w ? mw1 : mw0};
`ifdef COND_STATS_EN
      K_EXEC:  r = w ? ec1 : ec0;
      K_SKIP:  r = w ? sc1 : sc0;
`endif
      default: r = 4'hx;
    endcase
    return r;
  endfunction

  function automatic logic ref_cond(logic [3:0] c, logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic void expect_val(string name, bit w, int k, logic [3:0] v);
    exp_t e;
    e.name = name; e.which = w; e.kind = k; e.val = v;
    sb.push_back(e);
  endfunction

  function automatic void expect_we(string name, bit w, logic pc, logic rw, logic mw);
    expect_val({name, "_pcsrc"}, w, K_PC, {3'b000, pc});
    expect_val({name, "_regwrite"}, w, K_RW, {3'b000, rw});
    expect_val({name, "_memwrite"}, w, K_MW, {3'b000, mw});
  endfunction

  task automatic check_now(string name, logic [3:0] got, logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (immediate): got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = actual(e.which, e.kind);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s (dut%0d): got %h expected %h", e.name, e.which, a, e.val);
      end
    end
  end

  initial begin
    #500000;
    if (!done) begin
      errors++;
      $display("FAIL watchdog: wait expired before stimulus completed");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b11;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0; CondLatch = 1'b1;
    cyc();

    check_now("rst_now_flags0", fl0, 4'h0);
    check_now("rst_now_flags1", fl1, 4'h0);
    check_now("rst_now_ce_r", {3'b000, ce1}, 4'h0);
    check_now("rst_now_we1", {1'b0, pc1, rw1, mw1}, 4'h0);

    reset = 1'b0; FlagW = 2'b00; Cond = 4'h0; CondLatch = 1'b0;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    expect_val("rst_flags", 0, K_FLAGS, 4'h0);
    expect_val("rst_flags", 1, K_FLAGS, 4'h0);
    expect_val("rst_eq_ce", 0, K_CE, 4'h0);
    expect_val("rst_ce_r", 1, K_CE, 4'h0);
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
    expect_we("rst_mc", 1, 1'b0, 1'b0, 1'b0);
`ifdef COND_STATS_EN
    expect_val("rst_exec", 1, K_EXEC, 4'h0);
    expect_val("rst_skip", 1, K_SKIP, 4'h0);
    expect_val("rst_exec", 0, K_EXEC, 4'h0);
    expect_val("rst_skip", 0, K_SKIP, 4'h0);
`endif
    cyc();
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;

    Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b0110;
    expect_val("al_ce", 0, K_CE, 4'h1);
    cyc();
    expect_val("upd_nz", 0, K_FLAGS, 4'b0100);
    FlagW = 2'b01; ALUFlags = 4'b1011;
    cyc();
    expect_val("upd_cv", 0, K_FLAGS, 4'b0111);
    FlagW = 2'b00;

    for (int f = 0; f < 16; f++) begin
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = f[3:0];
      cyc();
      FlagW = 2'b00; ALUFlags = ~f[3:0];
      expect_val($sformatf("sweep_flags_%0d", f), 0, K_FLAGS, f[3:0]);
      for (int c = 0; c < 16; c++) begin
        Cond = c[3:0];
        expect_val($sformatf("cond_c%0d_f%0d", c, f), 0, K_CE,
                   {3'b000, ref_cond(c[3:0], f[3:0])});
        cyc();
      end
    end

    Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0100;
    cyc();
    Cond = 4'h1; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1011;
    expect_val("ne_fail_ce", 0, K_CE, 4'h0);
    expect_we("ne_fail", 0, 1'b0, 1'b0, 1'b0);
    cyc();
    expect_val("ne_fail_flags_hold", 0, K_FLAGS, 4'b0100);
    Cond = 4'h0; FlagW = 2'b00; NoWrite = 1'b1;
    expect_we("eq_nowrite", 0, 1'b1, 1'b0, 1'b1);
    cyc();
    NoWrite = 1'b0;
    expect_we("eq_write", 0, 1'b1, 1'b1, 1'b1);
    cyc();

    Cond = 4'hE; CondLatch = 1'b1;
    cyc();
    CondLatch = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0100;
    cyc();
    FlagW = 2'b00;
    expect_val("mc_flags_z", 1, K_FLAGS, 4'b0100);
    Cond = 4'h1; CondLatch = 1'b1;
    cyc();
    CondLatch = 1'b0;
    expect_val("mc_latch_ne", 1, K_CE, 4'h0);
    expect_we("mc_latch_ne", 1, 1'b0, 1'b0, 1'b0);
    Cond = 4'h0; CondLatch = 1'b1;
    cyc();
    CondLatch = 1'b0; Cond = 4'h1;
    for (int i = 0; i < 3; i++) begin
      expect_val($sformatf("mc_hold_%0d", i), 1, K_CE, 4'h1);
      expect_we($sformatf("mc_hold_%0d", i), 1, 1'b1, 1'b1, 1'b1);
      cyc();
    end

    Cond = 4'h0; CondLatch = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0000;
    cyc();
    CondLatch = 1'b0; FlagW = 2'b00;
    expect_val("same_edge_flags", 1, K_FLAGS, 4'b0000);
    expect_val("same_edge_ce_old_flags", 1, K_CE, 4'h1);
    CondLatch = 1'b1;
    cyc();
    CondLatch = 1'b0;
    expect_val("relatch_eq_z0", 1, K_CE, 4'h0);
    Cond = 4'hE; CondLatch = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
    cyc();
    CondLatch = 1'b0; FlagW = 2'b00;
    expect_val("same_edge_old_fail_flags", 1, K_FLAGS, 4'b0000);
    expect_val("same_edge_new_ce", 1, K_CE, 4'h1);
    cyc();

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    expect_val("midrst_ce", 1, K_CE, 4'h0);
    expect_we("midrst", 1, 1'b0, 1'b0, 1'b0);
`ifdef COND_STATS_EN
    expect_val("midrst_exec", 1, K_EXEC, 4'h0);
    expect_val("midrst_skip", 1, K_SKIP, 4'h0);
    Cond = 4'hE; CondLatch = 1'b1;
    repeat (20) cyc();
    CondLatch = 1'b0;
    expect_val("exec_sat", 1, K_EXEC, 4'hF);
    expect_val("skip_zero", 1, K_SKIP, 4'h0);
    expect_val("exec_sat_sc", 0, K_EXEC, 4'hF);
    Cond = 4'h0; CondLatch = 1'b1;
    repeat (3) cyc();
    CondLatch = 1'b0;
    expect_val("skip_three", 1, K_SKIP, 4'h3);
    expect_val("exec_still_sat", 1, K_EXEC, 4'hF);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    expect_val("stats_rst_exec", 1, K_EXEC, 4'h0);
    expect_val("stats_rst_skip", 1, K_SKIP, 4'h0);
    expect_val("stats_rst_exec", 0, K_EXEC, 4'h0);
    expect_val("stats_rst_skip", 0, K_SKIP, 4'h0);
`endif
    cyc();
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors == 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

endmodule
